// File: rtl/mult_seq_16b.sv
// rtl/mult_seq_16b.sv - sequential 16x16 shift-add multiplier driving an external 16-bit adder
//
// Purpose: computes a 2N-bit product over 16 RUN iterations. Each iteration
// uses one external combinational addition: partial-product high half plus
// either the multiplicand or zero.
//
// Optional feature macro: MULT_SIGNED_EN
//   defined   -> adds the sgn port and two's-complement operand handling
//   undefined -> unsigned only
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           multiply request, sampled only in IDLE
//   a, b            multiplicand / multiplier, captured at accept
//   sgn             signed-mode select (MULT_SIGNED_EN only)
//   busy            high from the cycle after accept through the DONE cycle
//   done            one-cycle pulse; product valid
//   product         result; held until the next completion or reset
//   add_a, add_b    external adder operands (zero outside RUN)
//   add_cin         external adder carry-in (constant 0)
//   add_s, add_cout external adder sum and carry-out
module mult_seq_16b #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef MULT_SIGNED_EN
    input  logic           sgn,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    output logic           add_cin,
    input  logic [N-1:0]   add_s,
    input  logic           add_cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [2*N-1:0] product_q, product_d;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [2*N-1:0] prod_raw;

`ifdef MULT_SIGNED_EN
    logic           neg_q, neg_d;

    // Magnitudes come from local negation so the external adder stays
    // dedicated to the iteration datapath. 0x8000 maps to itself, which is
    // the correct unsigned magnitude.
    always_comb begin
        a_mag = (sgn && a[N-1]) ? (~a + 1'b1) : a;
        b_mag = (sgn && b[N-1]) ? (~b + 1'b1) : b;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        product_d = product_q;
        prod_raw  = '0;
        add_a     = '0;
        add_b     = '0;
`ifdef MULT_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = a_mag;
                    lo_d    = b_mag;
                    hi_d    = '0;
                    cnt_d   = 4'd0;
`ifdef MULT_SIGNED_EN
                    neg_d   = sgn & (a[N-1] ^ b[N-1]);
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                add_a = hi_q;
                add_b = lo_q[0] ? mcand_q : '0;
                // Shift the 17-bit sum right by one across hi:lo; the carry
                // becomes the new top bit so no overflow is lost.
                hi_d  = {add_cout, add_s[N-1:1]};
                lo_d  = {add_s[0], lo_q[N-1:1]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    prod_raw = {hi_d, lo_d};
`ifdef MULT_SIGNED_EN
                    product_d = neg_q ? (~prod_raw + 1'b1) : prod_raw;
`else
                    product_d = prod_raw;
`endif
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            product_q <= '0;
`ifdef MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
`ifdef MULT_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;
    assign add_cin = 1'b0;

endmodule

// File: tb/tb_mult_seq_16b.sv
// tb/tb_mult_seq_16b.sv - self-checking bench for mult_seq_16b with an attached adder
module tb_mult_seq_16b;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
`ifdef MULT_SIGNED_EN
    logic        sgn;
`endif
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_s;
    logic        add_cout;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vs;
        logic [31:0] exp;
        logic        b0chk;
    } vec_t;

    vec_t vecs[$];

    mult_seq_16b #(.N(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
`ifdef MULT_SIGNED_EN
        .sgn      (sgn),
`endif
        .busy     (busy),
        .done     (done),
        .product  (product),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Stand-in for the downstream carry-lookahead adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic ms);
        logic [31:0] ea;
        logic [31:0] eb;
        ea = ms ? {{16{ma[15]}}, ma} : {16'd0, ma};
        eb = ms ? {{16{mb[15]}}, mb} : {16'd0, mb};
        return ea * eb;
    endfunction

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic ts,
                          input logic [31:0] exp, input logic b0chk, input string nm);
        int n;
        logic got;
        @(negedge clk);
        a = ta;
        b = tb2;
`ifdef MULT_SIGNED_EN
        sgn = ts;
`else
        if (ts) $display("note: signed vector %s run as unsigned", nm);
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({31'd0, busy}, 32'd1, {nm, " busy_after_accept"});
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            if (b0chk) chk({16'd0, add_b}, 32'd0, {nm, " add_b_zero"});
            chk({31'd0, add_cin}, 32'd0, {nm, " add_cin"});
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            chk(32'd0, 32'd1, {nm, " done_timeout"});
        end else begin
            chk(n, 32'd16, {nm, " latency"});
            chk(product, exp, {nm, " product"});
            chk({31'd0, busy}, 32'd1, {nm, " busy_in_done"});
        end
        @(posedge clk);
        #1;
        chk({31'd0, done}, 32'd0, {nm, " done_one_cycle"});
        chk({31'd0, busy}, 32'd0, {nm, " idle_busy"});
        chk({16'd0, add_a}, 32'd0, {nm, " idle_add_a"});
        chk(product, exp, {nm, " product_hold"});
    endtask

    initial begin
        int n;
        int nd;
        logic got;
        vec_t v;
        logic [15:0] ra;
        logic [15:0] rb;
        logic rs;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef MULT_SIGNED_EN
        sgn = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk({31'd0, busy}, 32'd0, "reset busy");
        chk({31'd0, done}, 32'd0, "reset done");
        chk(product, 32'd0, "reset product");
        chk({16'd0, add_a}, 32'd0, "reset add_a");
        chk({16'd0, add_b}, 32'd0, "reset add_b");
        chk({31'd0, add_cin}, 32'd0, "reset add_cin");
        rst = 1'b0;

        vecs.push_back('{16'd3,      16'd5,      1'b0, 32'h0000000F, 1'b0});
        vecs.push_back('{16'hFFFF,   16'hFFFF,   1'b0, 32'hFFFE0001, 1'b0});
        vecs.push_back('{16'h1234,   16'h0000,   1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{16'h0000,   16'hBEEF,   1'b0, 32'h00000000, 1'b0});
        vecs.push_back('{16'h8000,   16'h0002,   1'b0, 32'h00010000, 1'b0});
`ifdef MULT_SIGNED_EN
        vecs.push_back('{16'hFFFE,   16'h0003,   1'b1, 32'hFFFFFFFA, 1'b0});
        vecs.push_back('{16'h8000,   16'h8000,   1'b1, 32'h40000000, 1'b0});
        vecs.push_back('{16'hFFFE,   16'h0003,   1'b0, 32'h0002FFFA, 1'b0});
        vecs.push_back('{16'h0007,   16'hFFFF,   1'b1, 32'hFFFFFFF9, 1'b0});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_op(v.va, v.vb, v.vs, v.exp, v.b0chk, $sformatf("vec%0d", i));
        end

        // start pulses during RUN and DONE must be ignored
        @(negedge clk);
        a = 16'd7;
        b = 16'd9;
`ifdef MULT_SIGNED_EN
        sgn = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (n == 5) begin
                start = 1'b1;
                a = 16'd2;
                b = 16'd2;
            end
            if (done) begin
                got = 1'b1;
                start = 1'b1;
                a = 16'd2;
                b = 16'd2;
            end
        end
        chk(n, 32'd16, "busy_start latency");
        chk(product, 32'h3F, "busy_start product");
        @(posedge clk);
        #1 start = 1'b0;
        chk({31'd0, busy}, 32'd0, "busy_start not_queued");
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk(nd, 32'd0, "busy_start no_second_done");
        chk(product, 32'h3F, "busy_start product_hold");

        // reset in the middle of an operation
        @(negedge clk);
        a = 16'h00FF;
        b = 16'h0101;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk({31'd0, busy}, 32'd0, "midrst busy");
        chk({31'd0, done}, 32'd0, "midrst done");
        chk(product, 32'd0, "midrst product");
        chk({16'd0, add_a}, 32'd0, "midrst add_a");
        run_op(16'd2, 16'd3, 1'b0, 32'd6, 1'b0, "after_rst");

        // random operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
`ifdef MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, model(ra, rb, rs), 1'b0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
